// File: rtl/uart_mmio_ctrl_pkg.sv
// Shared address map and STATUS layout for the uart MMIO controller.
// Also provides a helper that packs the STATUS word.
package uart_mmio_ctrl_pkg;

  typedef enum logic [4:0] {
    ADR_STATUS    = 5'd0,
    ADR_RX_DATA   = 5'd1,
    ADR_TX_DATA   = 5'd2,
    ADR_CYCLE_CNT = 5'd4,
    ADR_INSTR_CNT = 5'd5,
    ADR_CNT_RST   = 5'd6
  } io_adr_e;

  localparam int STATUS_TX_FREE  = 0;
  localparam int STATUS_RX_AVAIL = 1;

  function automatic logic [31:0] status_word(input logic tx_free, input logic rx_avail);
    logic [31:0] w;
    w = '0;
    w[STATUS_TX_FREE]  = tx_free;
    w[STATUS_RX_AVAIL] = rx_avail;
    return w;
  endfunction

endpackage

// File: rtl/uart_mmio_ctrl_rx_fifo.sv
// Byte FIFO for received uart data with a first-word-fall-through head.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_mmio_ctrl_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/uart_mmio_ctrl.sv
// MMIO controller between the load/store port and the uart: address decode,
// RX FIFO, one-byte TX holding register, timing counters and registered load data.
module uart_mmio_ctrl
  import uart_mmio_ctrl_pkg::*;
#(
  parameter int RX_DEPTH = 8,
  parameter int CNT_W    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_en,
  input  logic [4:0]  adr,
  input  logic [3:0]  wea,
  input  logic        re,
  input  logic [31:0] wdata,
  input  logic        instr_retire,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);
  logic             load;
  logic             store;
  logic             rx_pop;
  logic             rx_push;
  logic             rx_full;
  logic             rx_empty;
  logic [7:0]       rx_head;
  logic             tx_accept;
  logic             cnt_clear;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;
  logic [31:0]      rdata_next;
  logic             unused_wdata;

  assign unused_wdata = ^wdata[31:8];

  assign load      = io_en & re;
  assign store     = io_en & (|wea);
  assign rx_pop    = load && (adr == ADR_RX_DATA) && !rx_empty;
  assign rx_push   = rx_valid & ~rx_full;
  assign rx_ready  = ~rx_full;
  // A byte leaving this cycle frees the holding register for a same-cycle store.
  assign tx_accept = store && (adr == ADR_TX_DATA) && (!tx_valid || tx_ready);
  assign cnt_clear = store && (adr == ADR_CNT_RST);

  uart_mmio_ctrl_rx_fifo #(
    .DEPTH(RX_DEPTH)
  ) io_rx_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (rx_push),
    .pop  (rx_pop),
    .din  (rx_data),
    .dout (rx_head),
    .full (rx_full),
    .empty(rx_empty)
  );

  always_comb begin
    rdata_next = rdata;
    if (load) begin
      case (adr)
        ADR_STATUS:    rdata_next = status_word(~tx_valid, ~rx_empty);
        ADR_RX_DATA:   rdata_next = rx_empty ? 32'd0 : {24'd0, rx_head};
        ADR_CYCLE_CNT: rdata_next = 32'(cycle_cnt);
        ADR_INSTR_CNT: rdata_next = 32'(instr_cnt);
        default:       rdata_next = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= 32'd0;
    end else begin
      rdata <= rdata_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid <= 1'b0;
      tx_data  <= 8'd0;
    end else if (tx_accept) begin
      tx_valid <= 1'b1;
      tx_data  <= wdata[7:0];
    end else if (tx_valid && tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else if (cnt_clear) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      instr_cnt <= instr_cnt + CNT_W'(instr_retire);
    end
  end

endmodule
